// File: rtl/ahb_arb_pkg.sv
// Shared types for the two-master AHB-Lite bus arbiter.
package ahb_arb_pkg;

  localparam int CTRL_ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_e;

  typedef logic mid_t;

  typedef struct packed {
    logic [CTRL_ADDR_W-1:0] addr;
    logic                   write;
    logic [2:0]             size;
    logic [2:0]             burst;
    logic [3:0]             prot;
    logic                   lock;
  } ahb_ctrl_t;

endpackage

// File: rtl/ahb_pend_slot.sv
// Holds one losing master's NONSEQ address phase until it is issued.
module ahb_pend_slot
  import ahb_arb_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      capture,
  input  logic      clear,
  input  ahb_ctrl_t d,
  output logic      valid,
  output ahb_ctrl_t q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (capture) begin
      valid <= 1'b1;
      q     <= d;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Two-master AHB-Lite arbiter with per-master pending slots.
// Define AHBARB_ROUND_ROBIN_EN for round-robin, else M0 has priority.
module ahb_bus_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] HADDR_M0,
  input  logic [1:0]        HTRANS_M0,
  input  logic              HWRITE_M0,
  input  logic [2:0]        HSIZE_M0,
  input  logic [2:0]        HBURST_M0,
  input  logic [3:0]        HPROT_M0,
  input  logic              HMASTLOCK_M0,
  input  logic [DATA_W-1:0] HWDATA_M0,
  output logic [DATA_W-1:0] HRDATA_M0,
  output logic              HREADY_M0,
  output logic              HRESP_M0,
  input  logic [ADDR_W-1:0] HADDR_M1,
  input  logic [1:0]        HTRANS_M1,
  input  logic              HWRITE_M1,
  input  logic [2:0]        HSIZE_M1,
  input  logic [2:0]        HBURST_M1,
  input  logic [3:0]        HPROT_M1,
  input  logic              HMASTLOCK_M1,
  input  logic [DATA_W-1:0] HWDATA_M1,
  output logic [DATA_W-1:0] HRDATA_M1,
  output logic              HREADY_M1,
  output logic              HRESP_M1,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic              HMASTLOCK,
  output logic [DATA_W-1:0] HWDATA,
  output logic              HMASTER,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  mid_t       owner;
  mid_t       data_owner;
  mid_t       sel;
  mid_t       win;
  logic       data_active;
  logic       hold;
  logic [1:0] req;
  logic [1:0] pv;
  logic [1:0] cap;
  logic [1:0] clr;
  logic [1:0] rdy;
  logic [1:0] etr [2];
  ahb_ctrl_t  live [2];
  ahb_ctrl_t  pq [2];
  ahb_ctrl_t  eff [2];

  assign live[0] = '{
    addr:  CTRL_ADDR_W'(HADDR_M0),
    write: HWRITE_M0,
    size:  HSIZE_M0,
    burst: HBURST_M0,
    prot:  HPROT_M0,
    lock:  HMASTLOCK_M0
  };

  assign live[1] = '{
    addr:  CTRL_ADDR_W'(HADDR_M1),
    write: HWRITE_M1,
    size:  HSIZE_M1,
    burst: HBURST_M1,
    prot:  HPROT_M1,
    lock:  HMASTLOCK_M1
  };

  ahb_pend_slot u_pend0 (
    .clk     (HCLK),
    .rst     (RESET),
    .capture (cap[0]),
    .clear   (clr[0]),
    .d       (live[0]),
    .valid   (pv[0]),
    .q       (pq[0])
  );

  ahb_pend_slot u_pend1 (
    .clk     (HCLK),
    .rst     (RESET),
    .capture (cap[1]),
    .clear   (clr[1]),
    .d       (live[1]),
    .valid   (pv[1]),
    .q       (pq[1])
  );

  // A pending slot always holds a NONSEQ, so it outranks the live port.
  always_comb begin
    eff[0] = pv[0] ? pq[0] : live[0];
    eff[1] = pv[1] ? pq[1] : live[1];
    etr[0] = pv[0] ? 2'(NONSEQ) : HTRANS_M0;
    etr[1] = pv[1] ? 2'(NONSEQ) : HTRANS_M1;
    req[0] = pv[0] | (HTRANS_M0 == NONSEQ);
    req[1] = pv[1] | (HTRANS_M1 == NONSEQ);
  end

  assign hold = !HREADY
              | (etr[owner] == SEQ)
              | (etr[owner] == BUSY)
              | eff[owner].lock;

`ifdef AHBARB_ROUND_ROBIN_EN
  mid_t rr_last;

  assign win = (&req) ? ~rr_last : req[1];

  always_ff @(posedge HCLK or posedge RESET) begin
    if (RESET) begin
      rr_last <= 1'b1;
    end else if (HREADY && HTRANS == NONSEQ) begin
      rr_last <= sel;
    end
  end
`else
  assign win = ~req[0];
`endif

  always_comb begin
    sel = owner;
    if (RESET) begin
      sel = 1'b0;
    end else if (!hold && |req) begin
      sel = win;
    end
  end

  assign HMASTER   = sel;
  assign HADDR     = ADDR_W'(eff[sel].addr);
  assign HTRANS    = etr[sel];
  assign HWRITE    = eff[sel].write;
  assign HSIZE     = eff[sel].size;
  assign HBURST    = eff[sel].burst;
  assign HPROT     = eff[sel].prot;
  assign HMASTLOCK = eff[sel].lock;

  // A waiting master is stalled through its own HREADY.
  always_comb begin
    rdy[0] = !pv[0];
    rdy[1] = !pv[1];
    if (data_active && data_owner == 1'b0) rdy[0] = HREADY;
    if (data_active && data_owner == 1'b1) rdy[1] = HREADY;
  end

  assign cap[0] = (sel != 1'b0) && (HTRANS_M0 == NONSEQ)
                && rdy[0] && !pv[0];
  assign cap[1] = (sel != 1'b1) && (HTRANS_M1 == NONSEQ)
                && rdy[1] && !pv[1];
  assign clr[0] = HREADY && (sel == 1'b0);
  assign clr[1] = HREADY && (sel == 1'b1);

  always_ff @(posedge HCLK or posedge RESET) begin
    if (RESET) begin
      owner       <= 1'b0;
      data_owner  <= 1'b0;
      data_active <= 1'b0;
    end else if (HREADY) begin
      owner       <= sel;
      data_active <= HTRANS[1];
      if (HTRANS[1]) data_owner <= sel;
    end
  end

  assign HREADY_M0 = rdy[0];
  assign HREADY_M1 = rdy[1];
  assign HRESP_M0  = data_active && data_owner == 1'b0 && HRESP;
  assign HRESP_M1  = data_active && data_owner == 1'b1 && HRESP;
  assign HRDATA_M0 = HRDATA;
  assign HRDATA_M1 = HRDATA;
  assign HWDATA    = data_owner ? HWDATA_M1 : HWDATA_M0;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Scoreboard bench for ahb_bus_arbiter: issued address phases are
// queued by a monitor and matched against per-scenario expectations.
module tb_ahb_bus_arbiter;
  import ahb_arb_pkg::*;

  logic        HCLK = 1'b0;
  logic        RESET;
  logic [31:0] HADDR_M0, HADDR_M1, HADDR;
  logic [1:0]  HTRANS_M0, HTRANS_M1, HTRANS;
  logic        HWRITE_M0, HWRITE_M1, HWRITE;
  logic [2:0]  HSIZE_M0, HSIZE_M1, HSIZE;
  logic [2:0]  HBURST_M0, HBURST_M1, HBURST;
  logic [3:0]  HPROT_M0, HPROT_M1, HPROT;
  logic        HMASTLOCK_M0, HMASTLOCK_M1, HMASTLOCK;
  logic [31:0] HWDATA_M0, HWDATA_M1, HWDATA;
  logic [31:0] HRDATA_M0, HRDATA_M1, HRDATA;
  logic        HREADY_M0, HREADY_M1, HREADY;
  logic        HRESP_M0, HRESP_M1, HRESP;
  logic        HMASTER;

  int errors = 0;
  int checks = 0;
  logic [32:0] exp_q[$];
  logic [32:0] obs_q[$];

  always #5 HCLK = ~HCLK;

  ahb_bus_arbiter dut (
    .HCLK(HCLK), .RESET(RESET),
    .HADDR_M0(HADDR_M0), .HTRANS_M0(HTRANS_M0),
    .HWRITE_M0(HWRITE_M0), .HSIZE_M0(HSIZE_M0),
    .HBURST_M0(HBURST_M0), .HPROT_M0(HPROT_M0),
    .HMASTLOCK_M0(HMASTLOCK_M0), .HWDATA_M0(HWDATA_M0),
    .HRDATA_M0(HRDATA_M0), .HREADY_M0(HREADY_M0),
    .HRESP_M0(HRESP_M0),
    .HADDR_M1(HADDR_M1), .HTRANS_M1(HTRANS_M1),
    .HWRITE_M1(HWRITE_M1), .HSIZE_M1(HSIZE_M1),
    .HBURST_M1(HBURST_M1), .HPROT_M1(HPROT_M1),
    .HMASTLOCK_M1(HMASTLOCK_M1), .HWDATA_M1(HWDATA_M1),
    .HRDATA_M1(HRDATA_M1), .HREADY_M1(HREADY_M1),
    .HRESP_M1(HRESP_M1),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HMASTER(HMASTER), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP)
  );

  // Every accepted NONSEQ/SEQ address phase, as {HMASTER, HADDR}.
  always @(negedge HCLK) begin
    if (!RESET && HREADY && HTRANS[1])
      obs_q.push_back({HMASTER, HADDR});
  end

  task automatic nxt();
    @(posedge HCLK);
    #1;
  endtask

  task automatic m0(input logic [1:0] t, input logic [31:0] a,
                    input logic w, input logic [2:0] b,
                    input logic l);
    HTRANS_M0 = t; HADDR_M0 = a; HWRITE_M0 = w;
    HBURST_M0 = b; HMASTLOCK_M0 = l;
  endtask

  task automatic m1(input logic [1:0] t, input logic [31:0] a,
                    input logic w, input logic [2:0] b,
                    input logic l);
    HTRANS_M1 = t; HADDR_M1 = a; HWRITE_M1 = w;
    HBURST_M1 = b; HMASTLOCK_M1 = l;
  endtask

  task automatic test_reset();
    logic [32:0] e, o;
    m0(IDLE, 32'h0000_0abc, 1'b0, 3'd0, 1'b0);
    m1(NONSEQ, 32'h5000_0000, 1'b1, 3'd0, 1'b0);
    HRESP = 1'b1;
    @(negedge HCLK);
    checks += 6;
    if (HMASTER !== 1'b0) begin errors++;
      $display("FAIL rst_hmaster got=%0h exp=0", HMASTER); end
    if (HREADY_M0 !== 1'b1) begin errors++;
      $display("FAIL rst_hready_m0 got=%0h exp=1", HREADY_M0); end
    if (HREADY_M1 !== 1'b1) begin errors++;
      $display("FAIL rst_hready_m1 got=%0h exp=1", HREADY_M1); end
    if (HRESP_M0 !== 1'b0 || HRESP_M1 !== 1'b0) begin errors++;
      $display("FAIL rst_hresp got=%0h%0h exp=00", HRESP_M0, HRESP_M1); end
    if (HADDR !== 32'h0000_0abc) begin errors++;
      $display("FAIL rst_haddr got=%h exp=00000abc", HADDR); end
    if (HTRANS !== 2'b00) begin errors++;
      $display("FAIL rst_htrans got=%0h exp=0", HTRANS); end
    nxt();
    RESET = 1'b0; HRESP = 1'b0;
    m1(NONSEQ, 32'h3000_0000, 1'b1, 3'b011, 1'b0);
    exp_q.push_back({1'b1, 32'h3000_0000});
    nxt();
    m1(SEQ, 32'h3000_0004, 1'b1, 3'b011, 1'b0);
    m0(NONSEQ, 32'h1000_0000, 1'b0, 3'd0, 1'b0);
    exp_q.push_back({1'b1, 32'h3000_0004});
    @(negedge HCLK);
    checks++;
    if (HREADY_M0 !== 1'b1) begin errors++;
      $display("FAIL rst_capture_m0 got=%0h exp=1", HREADY_M0); end
    nxt();
    m1(SEQ, 32'h3000_0008, 1'b1, 3'b011, 1'b0);
    m0(IDLE, 32'h0000_0abc, 1'b0, 3'd0, 1'b0);
    #1;
    checks++;
    if (HREADY_M0 !== 1'b0) begin errors++;
      $display("FAIL rst_pend0_set got=%0h exp=0", HREADY_M0); end
    RESET = 1'b1;
    @(negedge HCLK);
    checks += 3;
    if (HREADY_M0 !== 1'b1 || HREADY_M1 !== 1'b1) begin errors++;
      $display("FAIL midrst_hready got=%0h%0h exp=11",
               HREADY_M0, HREADY_M1); end
    if (HMASTER !== 1'b0) begin errors++;
      $display("FAIL midrst_hmaster got=%0h exp=0", HMASTER); end
    if (HADDR !== 32'h0000_0abc) begin errors++;
      $display("FAIL midrst_haddr got=%h exp=00000abc", HADDR); end
    nxt();
    RESET = 1'b0;
    m1(IDLE, 32'h0, 1'b0, 3'd0, 1'b0);
    repeat (3) nxt();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 33'h0;
      checks++;
      if (o !== e) begin errors++;
        $display("FAIL rst_issue got=%h exp=%h", o, e); end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++;
      $display("FAIL rst_replay got=%0d extra exp=0", obs_q.size());
      obs_q.delete(); end
  endtask

  task automatic test_contention();
    logic [32:0] e, o;
    m0(NONSEQ, 32'h2000_0000, 1'b1, 3'd0, 1'b0);
    m1(NONSEQ, 32'h5000_0000, 1'b1, 3'd0, 1'b0);
    exp_q.push_back({1'b0, 32'h2000_0000});
    exp_q.push_back({1'b1, 32'h5000_0000});
    @(negedge HCLK);
    checks += 2;
    if (HADDR !== 32'h2000_0000) begin errors++;
      $display("FAIL cont_n_haddr got=%h exp=20000000", HADDR); end
    if (HREADY_M1 !== 1'b1) begin errors++;
      $display("FAIL cont_n_capture got=%0h exp=1", HREADY_M1); end
    nxt();
    m0(IDLE, 32'h0, 1'b0, 3'd0, 1'b0);
    m1(IDLE, 32'h0, 1'b0, 3'd0, 1'b0);
    HWDATA_M0 = 32'haaaa_0000; HWDATA_M1 = 32'hbbbb_1111;
    @(negedge HCLK);
    checks += 5;
    if (HADDR !== 32'h5000_0000) begin errors++;
      $display("FAIL cont_n1_haddr got=%h exp=50000000", HADDR); end
    if (HMASTER !== 1'b1 || HWRITE !== 1'b1) begin errors++;
      $display("FAIL cont_n1_ctl got=%0h%0h exp=11", HMASTER, HWRITE); end
    if (HREADY_M1 !== 1'b0) begin errors++;
      $display("FAIL cont_n1_hready_m1 got=%0h exp=0", HREADY_M1); end
    if (HREADY_M0 !== 1'b1) begin errors++;
      $display("FAIL cont_n1_hready_m0 got=%0h exp=1", HREADY_M0); end
    if (HWDATA !== 32'haaaa_0000) begin errors++;
      $display("FAIL cont_n1_hwdata got=%h exp=aaaa0000", HWDATA); end
    nxt();
    HRESP = 1'b1; HRDATA = 32'h1234_5678;
    @(negedge HCLK);
    checks += 4;
    if (HWDATA !== 32'hbbbb_1111) begin errors++;
      $display("FAIL cont_n2_hwdata got=%h exp=bbbb1111", HWDATA); end
    if (HREADY_M1 !== 1'b1) begin errors++;
      $display("FAIL cont_n2_hready_m1 got=%0h exp=1", HREADY_M1); end
    if (HRESP_M1 !== 1'b1 || HRESP_M0 !== 1'b0) begin errors++;
      $display("FAIL cont_n2_hresp got=%0h%0h exp=01", HRESP_M0, HRESP_M1); end
    if (HRDATA_M0 !== 32'h1234_5678) begin errors++;
      $display("FAIL cont_n2_hrdata got=%h exp=12345678", HRDATA_M0); end
    nxt();
    HRESP = 1'b0;
    nxt();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 33'h0;
      checks++;
      if (o !== e) begin errors++;
        $display("FAIL cont_issue got=%h exp=%h", o, e); end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++;
      $display("FAIL cont_extra got=%0d exp=0", obs_q.size());
      obs_q.delete(); end
  endtask

  task automatic test_burst();
    logic [32:0] e, o;
    for (int b = 0; b < 4; b++) begin
      m1(b == 0 ? 2'(NONSEQ) : 2'(SEQ), 32'h2000_0100 + 32'(4 * b),
         1'b0, 3'b011, 1'b0);
      if (b == 1) m0(NONSEQ, 32'h1000_0040, 1'b1, 3'd0, 1'b0);
      else m0(IDLE, 32'h0, 1'b0, 3'd0, 1'b0);
      exp_q.push_back({1'b1, 32'h2000_0100 + 32'(4 * b)});
      @(negedge HCLK);
      checks += 2;
      if (HMASTER !== 1'b1) begin errors++;
        $display("FAIL burst_b%0d_hmaster got=%0h exp=1", b, HMASTER); end
      if (HREADY_M0 !== (b <= 1)) begin errors++;
        $display("FAIL burst_b%0d_hready_m0 got=%0h exp=%0h",
                 b, HREADY_M0, (b <= 1)); end
      nxt();
    end
    m1(IDLE, 32'h0, 1'b0, 3'd0, 1'b0);
    exp_q.push_back({1'b0, 32'h1000_0040});
    @(negedge HCLK);
    checks += 2;
    if (HMASTER !== 1'b0 || HADDR !== 32'h1000_0040) begin errors++;
      $display("FAIL burst_m0_issue got=%0h/%h exp=0/10000040",
               HMASTER, HADDR); end
    if (HREADY_M0 !== 1'b0) begin errors++;
      $display("FAIL burst_m0_stall got=%0h exp=0", HREADY_M0); end
    nxt();
    @(negedge HCLK);
    checks++;
    if (HREADY_M0 !== 1'b1) begin errors++;
      $display("FAIL burst_m0_data got=%0h exp=1", HREADY_M0); end
    nxt();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 33'h0;
      checks++;
      if (o !== e) begin errors++;
        $display("FAIL burst_issue got=%h exp=%h", o, e); end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++;
      $display("FAIL burst_extra got=%0d exp=0", obs_q.size());
      obs_q.delete(); end
  endtask

  task automatic test_wait();
    logic [32:0] e, o;
    m0(NONSEQ, 32'h0000_1000, 1'b0, 3'd0, 1'b0);
    exp_q.push_back({1'b0, 32'h0000_1000});
    nxt();
    m0(IDLE, 32'h0, 1'b0, 3'd0, 1'b0);
    m1(NONSEQ, 32'h4000_0000, 1'b1, 3'd0, 1'b0);
    HREADY = 1'b0;
    for (int w = 0; w < 3; w++) begin
      @(negedge HCLK);
      checks += 3;
      if (HMASTER !== 1'b0) begin errors++;
        $display("FAIL wait_w%0d_hmaster got=%0h exp=0", w, HMASTER); end
      if (HREADY_M0 !== 1'b0) begin errors++;
        $display("FAIL wait_w%0d_hready_m0 got=%0h exp=0", w, HREADY_M0); end
      if (HREADY_M1 !== (w == 0)) begin errors++;
        $display("FAIL wait_w%0d_hready_m1 got=%0h exp=%0h",
                 w, HREADY_M1, (w == 0)); end
      nxt();
      m1(IDLE, 32'h0, 1'b0, 3'd0, 1'b0);
    end
    HREADY = 1'b1;
    exp_q.push_back({1'b1, 32'h4000_0000});
    @(negedge HCLK);
    checks += 2;
    if (HMASTER !== 1'b1 || HADDR !== 32'h4000_0000) begin errors++;
      $display("FAIL wait_m1_issue got=%0h/%h exp=1/40000000",
               HMASTER, HADDR); end
    if (HREADY_M1 !== 1'b0) begin errors++;
      $display("FAIL wait_m1_stall got=%0h exp=0", HREADY_M1); end
    nxt();
    @(negedge HCLK);
    checks++;
    if (HREADY_M1 !== 1'b1) begin errors++;
      $display("FAIL wait_m1_data got=%0h exp=1", HREADY_M1); end
    nxt();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 33'h0;
      checks++;
      if (o !== e) begin errors++;
        $display("FAIL wait_issue got=%h exp=%h", o, e); end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++;
      $display("FAIL wait_extra got=%0d exp=0", obs_q.size());
      obs_q.delete(); end
  endtask

  task automatic test_lock();
    logic [32:0] e, o;
    m1(NONSEQ, 32'h6000_0000, 1'b0, 3'd0, 1'b1);
    exp_q.push_back({1'b1, 32'h6000_0000});
    nxt();
    m1(NONSEQ, 32'h6000_0000, 1'b1, 3'd0, 1'b1);
    m0(NONSEQ, 32'h2000_0200, 1'b0, 3'd0, 1'b0);
    exp_q.push_back({1'b1, 32'h6000_0000});
    @(negedge HCLK);
    checks += 2;
    if (HMASTER !== 1'b1 || HWRITE !== 1'b1) begin errors++;
      $display("FAIL lock_l2_ctl got=%0h%0h exp=11", HMASTER, HWRITE); end
    if (HMASTLOCK !== 1'b1) begin errors++;
      $display("FAIL lock_l2_hmastlock got=%0h exp=1", HMASTLOCK); end
    nxt();
    m1(IDLE, 32'h0, 1'b0, 3'd0, 1'b1);
    m0(IDLE, 32'h0, 1'b0, 3'd0, 1'b0);
    @(negedge HCLK);
    checks += 2;
    if (HMASTER !== 1'b1) begin errors++;
      $display("FAIL lock_l3_hmaster got=%0h exp=1", HMASTER); end
    if (HREADY_M0 !== 1'b0) begin errors++;
      $display("FAIL lock_l3_hready_m0 got=%0h exp=0", HREADY_M0); end
    nxt();
    m1(IDLE, 32'h0, 1'b0, 3'd0, 1'b0);
    exp_q.push_back({1'b0, 32'h2000_0200});
    @(negedge HCLK);
    checks++;
    if (HMASTER !== 1'b0 || HADDR !== 32'h2000_0200) begin errors++;
      $display("FAIL lock_release got=%0h/%h exp=0/20000200",
               HMASTER, HADDR); end
    nxt();
    nxt();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 33'h0;
      checks++;
      if (o !== e) begin errors++;
        $display("FAIL lock_issue got=%h exp=%h", o, e); end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++;
      $display("FAIL lock_extra got=%0d exp=0", obs_q.size());
      obs_q.delete(); end
  endtask

  task automatic test_continuous();
    logic [32:0] e, o;
    logic [31:0] a0, a1;
    logic        r0, r1, hm;
    RESET = 1'b1;
    nxt();
    RESET = 1'b0;
    nxt();
    a0 = 32'h2000_1000;
    a1 = 32'h5000_2000;
`ifdef AHBARB_ROUND_ROBIN_EN
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back({1'b0, a0 + 32'(4 * k)});
      exp_q.push_back({1'b1, a1 + 32'(4 * k)});
    end
    exp_q.push_back({1'b0, a0 + 32'd12});
`else
    for (int k = 0; k < 6; k++)
      exp_q.push_back({1'b0, a0 + 32'(4 * k)});
    exp_q.push_back({1'b1, a1});
`endif
    for (int c = 0; c < 6; c++) begin
      m0(NONSEQ, a0, 1'b1, 3'd0, 1'b0);
      m1(NONSEQ, a1, 1'b1, 3'd0, 1'b0);
      @(negedge HCLK);
`ifdef AHBARB_ROUND_ROBIN_EN
      hm = 1'(c % 2);
`else
      hm = 1'b0;
      if (c > 0) begin
        checks++;
        if (HREADY_M1 !== 1'b0) begin errors++;
          $display("FAIL cont_c%0d_hready_m1 got=%0h exp=0",
                   c, HREADY_M1); end
      end
`endif
      checks++;
      if (HMASTER !== hm) begin errors++;
        $display("FAIL cont_c%0d_hmaster got=%0h exp=%0h",
                 c, HMASTER, hm); end
      r0 = HREADY_M0;
      r1 = HREADY_M1;
      nxt();
      if (r0) a0 = a0 + 32'd4;
      if (r1) a1 = a1 + 32'd4;
    end
    m0(IDLE, 32'h0, 1'b0, 3'd0, 1'b0);
    m1(IDLE, 32'h0, 1'b0, 3'd0, 1'b0);
    nxt();
    nxt();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 33'h0;
      checks++;
      if (o !== e) begin errors++;
        $display("FAIL cont_issue got=%h exp=%h", o, e); end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++;
      $display("FAIL cont_extra got=%0d exp=0", obs_q.size());
      obs_q.delete(); end
  endtask

  initial begin
    RESET = 1'b1;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
    HSIZE_M0 = 3'b010; HSIZE_M1 = 3'b010;
    HPROT_M0 = 4'b0011; HPROT_M1 = 4'b0011;
    HWDATA_M0 = 32'h0; HWDATA_M1 = 32'h0;
    m0(IDLE, 32'h0, 1'b0, 3'd0, 1'b0);
    m1(IDLE, 32'h0, 1'b0, 3'd0, 1'b0);
    repeat (2) @(posedge HCLK);
    #1;
    test_reset();
    test_contention();
    test_burst();
    test_wait();
    test_lock();
    test_continuous();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
